// File: rtl/alu_seq_if.sv
// Valid/ready bundle linking the operand-fetch stage, the sequential ALU and writeback.
// The master side presents operands and takes results; the slave side is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       FuncCode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             OverflowFlag;
  logic             ZeroFlag;
  logic             IllegalFlag;

  modport master (
    output in_valid, A, B, FuncCode, out_ready,
    input  in_ready, out_valid, C, OverflowFlag, ZeroFlag, IllegalFlag
  );

  modport slave (
    input  in_valid, A, B, FuncCode, out_ready,
    output in_ready, out_valid, C, OverflowFlag, ZeroFlag, IllegalFlag
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arithmetic ops plus an iterative
// shift-add multiply, with result and flags registered and held until consumed.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  alu_seq_if.slave  bus
);
  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               ill_q, ill_d;

  logic [2*WIDTH-1:0] mul_sum_s;
  logic [WIDTH+1:0]   op_res_s;
  logic               is_mul_s;

  // Single-cycle result for every non-multiply code, packed as {illegal, overflow, result}.
  function automatic logic [WIDTH+1:0] alu_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [3:0]       code);
    logic [WIDTH-1:0] r;
    logic             ovf;
    logic             ill;
    r   = {WIDTH{1'b0}};
    ovf = 1'b0;
    ill = 1'b0;
    case (code)
      4'd0: begin
        r   = a + b;
        ovf = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      4'd1: begin
        r   = a - b;
        ovf = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~a;
      4'd5: begin
        r   = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
        ovf = (a == MIN_NEG);
      end
      4'd6: r = {a[WIDTH-2:0], 1'b0};
      4'd7: r = {a[MSB], a[WIDTH-1:1]};
      default: ill = 1'b1;
    endcase
    return {ill, ovf, r};
  endfunction

  assign is_mul_s      = MUL_EN && (bus.FuncCode == 4'd8);
  assign op_res_s      = alu_op(bus.A, bus.B, bus.FuncCode);
  assign mul_sum_s     = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q)
                                             : {(2*WIDTH){1'b0}});

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.out_valid    = (state_q == S_DONE);
  assign bus.C            = c_q;
  assign bus.OverflowFlag = ovf_q;
  assign bus.ZeroFlag     = zero_q;
  assign bus.IllegalFlag  = ill_q;

  // Next-state, multiply datapath and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d = bus.A;
          b_d = bus.B;
          if (is_mul_s) begin
            acc_d   = {(2*WIDTH){1'b0}};
            cnt_d   = {CW{1'b0}};
            state_d = S_EXEC;
          end else begin
            c_d     = op_res_s[WIDTH-1:0];
            ovf_d   = op_res_s[WIDTH];
            ill_d   = op_res_s[WIDTH+1];
            zero_d  = (op_res_s[WIDTH-1:0] == {WIDTH{1'b0}});
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        acc_d = mul_sum_s;
        cnt_d = cnt_q + CW'(1);
        // The last partial product is folded in on the same edge that publishes the result.
        if (cnt_q == CNT_LAST) begin
          c_d     = mul_sum_s[WIDTH-1:0];
          ovf_d   = (mul_sum_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
          ill_d   = 1'b0;
          zero_d  = (mul_sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
          state_d = S_DONE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand, accumulator and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CW{1'b0}};
      c_q     <= {WIDTH{1'b0}};
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: two instances (multiply enabled/disabled) checked
// against an arithmetic reference model plus hand-computed literal results.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Expected {illegal, zero, overflow, C} for the op currently in flight on each DUT.
  logic [18:0] exp0 = 19'd0;
  logic [18:0] exp1 = 19'd0;

  alu_seq_if #(.WIDTH(16)) bus0 ();
  alu_seq_if #(.WIDTH(16)) bus1 ();

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
  alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: signed arithmetic on ints, full-width product, overflow by range test.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] code, input bit mul_en);
    int          sa, sb, r;
    longint      p;
    logic [15:0] c;
    logic        ovf, ill;
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 16'd0; ovf = 1'b0; ill = 1'b0;
    case (code)
      4'd0: begin r = sa + sb; c = r[15:0]; ovf = (r > 32767) || (r < -32768); end
      4'd1: begin r = sa - sb; c = r[15:0]; ovf = (r > 32767) || (r < -32768); end
      4'd2: c = a & b;
      4'd3: c = a | b;
      4'd4: c = ~a;
      4'd5: begin r = -sa; c = r[15:0]; ovf = (r > 32767); end
      4'd6: begin r = int'(a) * 2; c = r[15:0]; end
      4'd7: begin r = sa >>> 1; c = r[15:0]; end
      4'd8: begin
        if (mul_en) begin
          p = longint'(a) * longint'(b);
          c = p[15:0];
          ovf = (p > 64'sd65535);
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    return {ill, (c == 16'd0), ovf, c};
  endfunction

  // Whenever a result is presented, it must match the model and the input side must be closed.
  always @(negedge clk) begin
    if (!rst && bus0.out_valid) begin
      chk("cmp0_C", {16'd0, bus0.C}, {16'd0, exp0[15:0]});
      chk("cmp0_flags", {29'd0, bus0.IllegalFlag, bus0.ZeroFlag, bus0.OverflowFlag},
          {29'd0, exp0[18:16]});
      chk("cmp0_in_ready", {31'd0, bus0.in_ready}, 32'd0);
    end
    if (!rst && bus1.out_valid) begin
      chk("cmp1_C", {16'd0, bus1.C}, {16'd0, exp1[15:0]});
      chk("cmp1_flags", {29'd0, bus1.IllegalFlag, bus1.ZeroFlag, bus1.OverflowFlag},
          {29'd0, exp1[18:16]});
      chk("cmp1_in_ready", {31'd0, bus1.in_ready}, 32'd0);
    end
  end

  // Issue one op on DUT sel, check latency and literal result; bp>0 stalls the consumer.
  task automatic run_op(input string name, input bit sel, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] code,
                        input logic [15:0] lit_c, input logic [2:0] lit_izo,
                        input int lat_req, input int bp);
    int w, lat;
    logic rdy, ov;
    @(negedge clk);
    w = 0;
    rdy = sel ? bus1.in_ready : bus0.in_ready;
    while (!rdy && w < 50) begin
      @(negedge clk);
      w++;
      rdy = sel ? bus1.in_ready : bus0.in_ready;
    end
    chk({name, "_ready"}, {31'd0, rdy}, 32'd1);
    if (sel) begin
      exp1 = model(a, b, code, 1'b0);
      bus1.A = a; bus1.B = b; bus1.FuncCode = code; bus1.in_valid = 1'b1;
      bus1.out_ready = (bp == 0);
    end else begin
      exp0 = model(a, b, code, 1'b1);
      bus0.A = a; bus0.B = b; bus0.FuncCode = code; bus0.in_valid = 1'b1;
      bus0.out_ready = (bp == 0);
    end
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    lat = 1;
    ov = sel ? bus1.out_valid : bus0.out_valid;
    while (!ov && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      ov = sel ? bus1.out_valid : bus0.out_valid;
    end
    chk({name, "_latency"}, lat, lat_req);
    if (sel) begin
      chk({name, "_C"}, {16'd0, bus1.C}, {16'd0, lit_c});
      chk({name, "_flags"}, {29'd0, bus1.IllegalFlag, bus1.ZeroFlag, bus1.OverflowFlag},
          {29'd0, lit_izo});
    end else begin
      chk({name, "_C"}, {16'd0, bus0.C}, {16'd0, lit_c});
      chk({name, "_flags"}, {29'd0, bus0.IllegalFlag, bus0.ZeroFlag, bus0.OverflowFlag},
          {29'd0, lit_izo});
    end
    if (bp > 0) begin
      // A competing request during the stall must be ignored.
      bus0.A = 16'hFFFF; bus0.B = 16'h0001; bus0.FuncCode = 4'd0; bus0.in_valid = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(posedge clk); #1;
        chk({name, "_bp_valid"}, {31'd0, bus0.out_valid}, 32'd1);
        chk({name, "_bp_ready"}, {31'd0, bus0.in_ready}, 32'd0);
        chk({name, "_bp_C"}, {16'd0, bus0.C}, {16'd0, lit_c});
      end
      @(negedge clk);
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    ov = sel ? bus1.out_valid : bus0.out_valid;
    chk({name, "_drop"}, {31'd0, ov}, 32'd0);
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
  endtask

  initial begin
    int seen;
    bus0.in_valid = 1'b0; bus0.A = 16'd0; bus0.B = 16'd0; bus0.FuncCode = 4'd0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.A = 16'd0; bus1.B = 16'd0; bus1.FuncCode = 4'd0; bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("rst_C", {16'd0, bus0.C}, 32'd0);
    chk("rst_flags", {29'd0, bus0.IllegalFlag, bus0.ZeroFlag, bus0.OverflowFlag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // literal flags are {illegal, zero, overflow}
    run_op("add_ovf",  1'b0, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 3'b001, 1, 0);
    run_op("sub_ovf",  1'b0, 16'h8000, 16'h0001, 4'd1, 16'h7FFF, 3'b001, 1, 0);
    run_op("sub_zero", 1'b0, 16'h1234, 16'h1234, 4'd1, 16'h0000, 3'b010, 1, 0);
    run_op("neg_min",  1'b0, 16'h8000, 16'h0000, 4'd5, 16'h8000, 3'b001, 1, 0);
    run_op("neg_one",  1'b0, 16'h0001, 16'h0000, 4'd5, 16'hFFFF, 3'b000, 1, 0);
    run_op("asr",      1'b0, 16'h8002, 16'h0000, 4'd7, 16'hC001, 3'b000, 1, 0);
    run_op("shl",      1'b0, 16'h8001, 16'h0000, 4'd6, 16'h0002, 3'b000, 1, 0);
    run_op("and",      1'b0, 16'hF0F0, 16'h3C3C, 4'd2, 16'h3030, 3'b000, 1, 0);
    run_op("or",       1'b0, 16'hF0F0, 16'h3C3C, 4'd3, 16'hFCFC, 3'b000, 1, 0);
    run_op("not",      1'b0, 16'h00FF, 16'h0000, 4'd4, 16'hFF00, 3'b000, 1, 0);
    run_op("add_wrap", 1'b0, 16'h8000, 16'h8000, 4'd0, 16'h0000, 3'b011, 1, 0);
    run_op("add_nov",  1'b0, 16'h0001, 16'hFFFF, 4'd0, 16'h0000, 3'b010, 1, 0);
    run_op("mul_ff",   1'b0, 16'h00FF, 16'h0101, 4'd8, 16'hFFFF, 3'b000, 17, 0);
    run_op("mul_ovf",  1'b0, 16'h0100, 16'h0100, 4'd8, 16'h0000, 3'b011, 17, 0);
    run_op("mul_max",  1'b0, 16'hFFFF, 16'hFFFF, 4'd8, 16'h0001, 3'b001, 17, 0);
    run_op("ill9",     1'b0, 16'h1234, 16'h5678, 4'd9, 16'h0000, 3'b110, 1, 0);
    run_op("bp_add",   1'b0, 16'h1234, 16'h1111, 4'd0, 16'h2345, 3'b000, 1, 5);
    run_op("after_bp", 1'b0, 16'h0003, 16'h0005, 4'd8, 16'h000F, 3'b000, 17, 0);
    run_op("nomul8",   1'b1, 16'h0002, 16'h0003, 4'd8, 16'h0000, 3'b110, 1, 0);
    run_op("nomul_add",1'b1, 16'h0002, 16'h0003, 4'd0, 16'h0005, 3'b000, 1, 0);

    // Reset in the middle of a multiply discards it at once.
    @(negedge clk);
    bus0.A = 16'h1234; bus0.B = 16'h00FF; bus0.FuncCode = 4'd8; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstx_in_ready", {31'd0, bus0.in_ready}, 32'd1);
    chk("rstx_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("rstx_C", {16'd0, bus0.C}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.out_valid) seen++;
    end
    chk("rstx_no_pulse", seen, 0);
    run_op("post_rst", 1'b0, 16'h0010, 16'h0020, 4'd8, 16'h0200, 3'b000, 17, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
